// File: rtl/clock_seg_display_if.sv
// rtl/clock_seg_display_if.sv - time input and display drive bundle for clock_seg_display
// Purpose: groups the binary time inputs and the multiplexed 7-segment outputs.
// Signals:
//   hrs, mins, secs  binary time fields (6 bits each), driven by the time source
//   an               digit enables, active low (an[5]=H tens .. an[0]=S ones)
//   seg              segments gfedcba, active low (seg[6]=g)
//   dp               decimal point, active low
//   frame_start      one-cycle pulse when the scan wraps to digit 0
// Modports: master = time source / display observer, slave = display driver.
interface clock_seg_display_if;
  logic [5:0] hrs;
  logic [5:0] mins;
  logic [5:0] secs;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  modport master (output hrs, mins, secs, input an, seg, dp, frame_start);
  modport slave  (input hrs, mins, secs, output an, seg, dp, frame_start);
endinterface

// File: rtl/clock_seg_display.sv
// rtl/clock_seg_display.sv - 6-digit multiplexed common-anode 7-segment HH MM SS driver
// Purpose: refresh prescaler, digit scan counter, per-frame snapshot of the time
//   fields and a binary-to-digit/segment decoder; all outputs registered.
// Optional feature macro: COLON_BLINK_EN (dp lit on H ones and M ones on even seconds).
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   disp  clock_seg_display_if.slave: hrs/mins/secs in, an/seg/dp/frame_start out
// Parameter:
//   REFRESH_DIV  clk cycles per digit slot (>= 1)
module clock_seg_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  clock_seg_display_if.slave   disp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [PW-1:0] count;
  logic          tick;
  logic [2:0]    idx;
  logic [2:0]    idx_next;
  logic          wrap;
  logic [5:0]    snap_h, snap_m, snap_s;
  logic [5:0]    src_h, src_m, src_s;
  logic [5:0]    field;
  logic          field_bad;
  logic [5:0]    tens;
  logic [5:0]    ones;
  logic [5:0]    digit;
  logic [5:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  function automatic logic [6:0] encode(input logic [5:0] d);
    case (d)
      6'd0:    encode = 7'b1000000;
      6'd1:    encode = 7'b1111001;
      6'd2:    encode = 7'b0100100;
      6'd3:    encode = 7'b0110000;
      6'd4:    encode = 7'b0011001;
      6'd5:    encode = 7'b0010010;
      6'd6:    encode = 7'b0000010;
      6'd7:    encode = 7'b1111000;
      6'd8:    encode = 7'b0000000;
      6'd9:    encode = 7'b0010000;
      default: encode = SEG_DASH;
    endcase
  endfunction

  assign tick     = (count == LAST);
  assign idx_next = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
  assign wrap     = tick && (idx == 3'd5);

  // Digit 0 is decoded from the values being captured on this very edge,
  // so the live inputs are used when the scan is about to wrap.
  assign src_h = (idx == 3'd5) ? disp.hrs  : snap_h;
  assign src_m = (idx == 3'd5) ? disp.mins : snap_m;
  assign src_s = (idx == 3'd5) ? disp.secs : snap_s;

  always_comb begin
    field     = src_s;
    field_bad = 1'b0;
    case (idx_next[2:1])
      2'd0: begin
        field     = src_h;
        field_bad = (src_h > 6'd23);
      end
      2'd1: begin
        field     = src_m;
        field_bad = (src_m > 6'd59);
      end
      default: begin
        field     = src_s;
        field_bad = (src_s > 6'd59);
      end
    endcase
    tens     = field / 6'd10;
    ones     = field % 6'd10;
    // Even slots carry the tens digit, odd slots the ones digit.
    digit    = idx_next[0] ? ones : tens;
    seg_next = field_bad ? SEG_DASH : encode(digit);
    an_next  = ~(6'b100000 >> idx_next);
`ifdef COLON_BLINK_EN
    dp_next  = ((idx_next == 3'd1) || (idx_next == 3'd3)) ? src_s[0] : 1'b1;
`else
    dp_next  = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count            <= '0;
      idx              <= 3'd5;
      snap_h           <= '0;
      snap_m           <= '0;
      snap_s           <= '0;
      disp.an          <= 6'b111111;
      disp.seg         <= 7'b1111111;
      disp.dp          <= 1'b1;
      disp.frame_start <= 1'b0;
    end else begin
      count            <= tick ? '0 : count + PW'(1);
      disp.frame_start <= wrap;
      if (wrap) begin
        snap_h <= disp.hrs;
        snap_m <= disp.mins;
        snap_s <= disp.secs;
      end
      if (tick) begin
        idx      <= idx_next;
        disp.an  <= an_next;
        disp.seg <= seg_next;
        disp.dp  <= dp_next;
      end
    end
  end

endmodule

// File: tb/tb_clock_seg_display.sv
// tb/tb_clock_seg_display.sv - self-checking bench for clock_seg_display
module tb_clock_seg_display;

  logic clk;
  logic rst;

  clock_seg_display_if ia ();
  clock_seg_display_if ib ();

  clock_seg_display #(.REFRESH_DIV(4)) u_div4 (.clk(clk), .rst(rst), .disp(ia));
  clock_seg_display #(.REFRESH_DIV(1)) u_div1 (.clk(clk), .rst(rst), .disp(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  function automatic void push_frame(input int h, input int m, input int s);
    exp_t e;
    int   f;
    bit   bad;
    logic [5:0] one_hot;
    for (int k = 0; k < 6; k++) begin
      f   = (k < 2) ? h : ((k < 4) ? m : s);
      bad = (k < 2) ? (h > 23) : (f > 59);
      one_hot = 6'b100000 >> k;
      e.an  = ~one_hot;
      e.seg = bad ? 7'b0111111 : seg_of((k % 2) ? (f % 10) : (f / 10));
`ifdef COLON_BLINK_EN
      e.dp  = ((k == 1 || k == 3) && (s % 2 == 0)) ? 1'b0 : 1'b1;
`else
      e.dp  = 1'b1;
`endif
      sbq.push_back(e);
    end
  endfunction

  // Waits for each new digit on the DIV=4 instance and compares it against the scoreboard.
  task automatic drain_a(input int n, input string tag);
    exp_t       e;
    logic [5:0] prev;
    int         cyc;
    for (int i = 0; i < n; i++) begin
      prev = ia.an;
      cyc  = 0;
      while (ia.an === prev && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      e = sbq.pop_front();
      checks++;
      if (ia.an === prev) begin
        $display("FAIL %s timeout waiting for digit %0d: an=%b expected %b", tag, i, ia.an, e.an);
      end else if (ia.an !== e.an || ia.seg !== e.seg || ia.dp !== e.dp) begin
        $display("FAIL %s digit %0d: an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                 tag, i, ia.an, ia.seg, ia.dp, e.an, e.seg, e.dp);
      end else begin
        passed++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (ia.an !== 6'b111111 || ia.seg !== 7'b1111111 || ia.dp !== 1'b1 || ia.frame_start !== 1'b0)
      $display("FAIL reset_a: an=%b seg=%b dp=%b fs=%b expected 111111 1111111 1 0",
               ia.an, ia.seg, ia.dp, ia.frame_start);
    else passed++;
    checks++;
    if (ib.an !== 6'b111111 || ib.seg !== 7'b1111111 || ib.dp !== 1'b1 || ib.frame_start !== 1'b0)
      $display("FAIL reset_b: an=%b seg=%b dp=%b fs=%b expected 111111 1111111 1 0",
               ib.an, ib.seg, ib.dp, ib.frame_start);
    else passed++;
  endtask

  // Releases reset and checks the 3-cycle blank period, digit 0 with frame_start, then the rest.
  task automatic test_restart_frame(input int h, input int m, input int s, input string tag);
    exp_t e;
    ia.hrs = 6'(h); ia.mins = 6'(m); ia.secs = 6'(s);
    push_frame(h, m, s);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (ia.an !== 6'b111111 || ia.frame_start !== 1'b0)
        $display("FAIL %s blank cycle %0d: an=%b fs=%b expected 111111 0", tag, i, ia.an, ia.frame_start);
      else passed++;
    end
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (ia.an !== e.an || ia.seg !== e.seg || ia.frame_start !== 1'b1)
      $display("FAIL %s first digit: an=%b seg=%b fs=%b expected an=%b seg=%b fs=1",
               tag, ia.an, ia.seg, ia.frame_start, e.an, e.seg);
    else passed++;
    @(negedge clk);
    checks++;
    if (ia.frame_start !== 1'b0)
      $display("FAIL %s frame_start width: fs=%b expected 0", tag, ia.frame_start);
    else passed++;
    drain_a(5, tag);
  endtask

  task automatic test_tearing();
    ia.hrs = 6'd23; ia.mins = 6'd59; ia.secs = 6'd59;
    push_frame(23, 59, 59);
    drain_a(3, "tear_head");
    ia.hrs = 6'd0; ia.mins = 6'd0; ia.secs = 6'd0;
    drain_a(3, "tear_tail");
    push_frame(0, 0, 0);
    drain_a(6, "tear_next");
  endtask

  task automatic test_out_of_range();
    ia.hrs = 6'd24; ia.mins = 6'd7; ia.secs = 6'd60;
    push_frame(24, 7, 60);
    drain_a(6, "range");
    ia.hrs = 6'd63; ia.mins = 6'd60; ia.secs = 6'd0;
    push_frame(63, 60, 0);
    drain_a(6, "range_max");
  endtask

  task automatic test_colon();
    ia.hrs = 6'd1; ia.mins = 6'd2; ia.secs = 6'd10;
    push_frame(1, 2, 10);
    drain_a(6, "colon_even");
    ia.secs = 6'd11;
    push_frame(1, 2, 11);
    drain_a(6, "colon_odd");
  endtask

  task automatic test_async_reset();
    ia.hrs = 6'd15; ia.mins = 6'd42; ia.secs = 6'd8;
    push_frame(15, 42, 8);
    drain_a(4, "async_pre");
    sbq.delete();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (ia.an !== 6'b111111 || ia.seg !== 7'b1111111 || ia.frame_start !== 1'b0 || ia.dp !== 1'b1)
      $display("FAIL async_reset: an=%b seg=%b fs=%b dp=%b expected 111111 1111111 0 1",
               ia.an, ia.seg, ia.frame_start, ia.dp);
    else passed++;
    test_restart_frame(7, 8, 9, "async_recover");
  endtask

  task automatic test_div1();
    exp_t e;
    int   cyc;
    ib.hrs = 6'd0; ib.mins = 6'd0; ib.secs = 6'd9;
    @(negedge clk);
    cyc = 0;
    while (ib.frame_start !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (ib.frame_start !== 1'b1) begin
      $display("FAIL div1_sync: frame_start=%b expected 1 within 20 cycles", ib.frame_start);
    end else begin
      passed++;
      push_frame(0, 0, 9);
      push_frame(0, 0, 9);
      for (int k = 0; k < 12; k++) begin
        e = sbq.pop_front();
        checks++;
        if (ib.an !== e.an || ib.seg !== e.seg || ib.frame_start !== (k % 6 == 0))
          $display("FAIL div1 cycle %0d: an=%b seg=%b fs=%b expected an=%b seg=%b fs=%0d",
                   k, ib.an, ib.seg, ib.frame_start, e.an, e.seg, (k % 6 == 0));
        else passed++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    ia.hrs = '0; ia.mins = '0; ia.secs = '0;
    ib.hrs = 6'd0; ib.mins = 6'd0; ib.secs = 6'd9;
    #2;
    test_reset();
    test_restart_frame(12, 34, 56, "first_frame");
    test_tearing();
    test_out_of_range();
    test_colon();
    test_async_reset();
    test_div1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
